// File: rtl/sntc_ldpc_iter_ctrl_pkg.sv
// sntc_ldpc_iter_pkg: state codes, termination reasons and width constants for the LDPC iteration controller
package sntc_ldpc_iter_pkg;
  localparam int STATE_W = 3;
  localparam int REASON_W = 2;
  typedef logic [STATE_W-1:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_LAUNCH = 3'd1;
  localparam state_t S_WAIT = 3'd2;
  localparam state_t S_EVAL = 3'd3;
  localparam state_t S_FIN = 3'd4;
  typedef enum logic [REASON_W-1:0] {
    R_CONV = 2'd0,
    R_MAXIT = 2'd1,
    R_STALL = 2'd2,
    R_ABORT = 2'd3
  } reason_e;
endpackage

// File: rtl/sntc_ldpc_iter_ctrl.sv
// sntc_ldpc_iter_ctrl: LDPC bit-flip run FSM; host start/busy/done/pass/reason, core iter_start/iter_done/syn_wt, best-weight tracking with capture_best
module sntc_ldpc_iter_ctrl
  import sntc_ldpc_iter_pkg::*;
#(
  parameter int MM = 168,
  parameter int WT_W = $clog2(MM + 1),
  parameter int ITER_W = 8,
  parameter int STALL_W = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [ITER_W-1:0]  cfg_max_iter,
  input  logic [WT_W-1:0]    cfg_wt_thresh,
  input  logic [STALL_W-1:0] cfg_stall_lim,
  input  logic               cfg_stall_en,
  input  logic               abort,
  output logic               iter_start,
  input  logic               iter_done,
  input  logic [WT_W-1:0]    syn_wt,
  output logic               capture_best,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [1:0]         reason,
  output logic [ITER_W-1:0]  iter_cnt,
  output logic [WT_W-1:0]    best_wt,
  output logic [ITER_W-1:0]  best_iter
);
  state_t st;
  logic [ITER_W-1:0] max_q, max_eff;
  logic [WT_W-1:0] thr_q, wt_q;
  logic [STALL_W-1:0] lim_q, stall_cnt, stall_nxt;
  logic sen_q, abort_q, ab, imp;
  always_comb begin
    ab = abort | abort_q;
    imp = wt_q < best_wt;
    stall_nxt = imp ? '0 : (&stall_cnt ? stall_cnt : stall_cnt + 1'b1);
    max_eff = max_q == '0 ? ITER_W'(1) : max_q;
    busy = st == S_LAUNCH || st == S_WAIT || st == S_EVAL;
    iter_start = st == S_LAUNCH && !abort_q;
    capture_best = st == S_EVAL && imp;
    done = st == S_FIN;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      st <= S_IDLE;
      pass <= 1'b0;
      reason <= R_CONV;
      iter_cnt <= '0;
      best_iter <= '0;
      best_wt <= '1;
      stall_cnt <= '0;
      abort_q <= 1'b0;
      wt_q <= '0;
      max_q <= '0;
      thr_q <= '0;
      lim_q <= '0;
      sen_q <= 1'b0;
    end else begin
      if (busy && abort) abort_q <= 1'b1;
      case (st)
        S_IDLE: if (start) begin
          max_q <= cfg_max_iter;
          thr_q <= cfg_wt_thresh;
          lim_q <= cfg_stall_lim;
          sen_q <= cfg_stall_en;
          iter_cnt <= '0;
          best_iter <= '0;
          stall_cnt <= '0;
          pass <= 1'b0;
          reason <= R_CONV;
          abort_q <= 1'b0;
          best_wt <= '1;
          st <= S_LAUNCH;
        end
        S_LAUNCH: begin
          if (abort_q) reason <= R_ABORT;
          st <= abort_q ? S_FIN : S_WAIT;
        end
        S_WAIT: if (iter_done) begin
          wt_q <= syn_wt;
          iter_cnt <= &iter_cnt ? iter_cnt : iter_cnt + 1'b1;
          st <= S_EVAL;
        end else if (ab) begin
          reason <= R_ABORT;
          st <= S_FIN;
        end
        S_EVAL: begin
          if (imp) begin
            best_wt <= wt_q;
            best_iter <= iter_cnt;
          end
          stall_cnt <= stall_nxt;
          st <= S_FIN;
          if (wt_q <= thr_q) begin
            pass <= 1'b1;
            reason <= R_CONV;
          end else if (ab) reason <= R_ABORT;
          else if (iter_cnt >= max_eff) reason <= R_MAXIT;
          else if (sen_q && lim_q != '0 && stall_nxt >= lim_q) reason <= R_STALL;
          else st <= S_LAUNCH;
        end
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sntc_ldpc_iter_ctrl.sv
// tb_sntc_ldpc_iter_ctrl: directed table-driven and sequence checks for the LDPC iteration controller
module tb_sntc_ldpc_iter_ctrl;
  typedef struct packed {
    int mx;
    int th;
    int lim;
    int sen;
    int poke;
    logic [0:7][31:0] w;
    int rsn;
    int ps;
    int it;
    int bw;
    int bi;
    int nl;
    int nc;
  } vec_t;
  logic clk = 1'b0;
  logic clr, start, cfg_stall_en, abort, iter_done;
  logic iter_start, capture_best, busy, done, pass;
  logic [7:0] cfg_max_iter, cfg_wt_thresh, syn_wt, iter_cnt, best_wt, best_iter;
  logic [3:0] cfg_stall_lim;
  logic [1:0] reason;
  int checks = 0;
  int errors = 0;
  vec_t vt[8];
  always #5 clk = ~clk;
  sntc_ldpc_iter_ctrl dut (
    .clk(clk), .clr(clr), .start(start), .cfg_max_iter(cfg_max_iter),
    .cfg_wt_thresh(cfg_wt_thresh), .cfg_stall_lim(cfg_stall_lim),
    .cfg_stall_en(cfg_stall_en), .abort(abort), .iter_start(iter_start),
    .iter_done(iter_done), .syn_wt(syn_wt), .capture_best(capture_best),
    .busy(busy), .done(done), .pass(pass), .reason(reason), .iter_cnt(iter_cnt),
    .best_wt(best_wt), .best_iter(best_iter)
  );
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " pass"}, int'(pass), 0);
    chk({tag, " iter_start"}, int'(iter_start), 0);
    chk({tag, " capture_best"}, int'(capture_best), 0);
    chk({tag, " reason"}, int'(reason), 0);
    chk({tag, " iter_cnt"}, int'(iter_cnt), 0);
    chk({tag, " best_iter"}, int'(best_iter), 0);
    chk({tag, " best_wt"}, int'(best_wt), 255);
  endtask
  task automatic go(input int mx, input string tag);
    @(negedge clk);
    cfg_max_iter = mx[7:0];
    cfg_wt_thresh = 8'd0;
    cfg_stall_lim = 4'd0;
    cfg_stall_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " first launch"}, int'(iter_start), 1);
  endtask
  task automatic run(input vec_t v, input string tag);
    int idx = 0;
    int nl = 0;
    int nc = 0;
    logic resp = 1'b0;
    logic fin = 1'b0;
    @(negedge clk);
    cfg_max_iter = v.mx[7:0];
    cfg_wt_thresh = v.th[7:0];
    cfg_stall_lim = v.lim[3:0];
    cfg_stall_en = v.sen[0];
    start = 1'b1;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      @(negedge clk);
      start = v.poke != 0 && cyc == 2;
      cfg_max_iter = (v.poke != 0 && cyc == 2) ? 8'd1 : v.mx[7:0];
      iter_done = 1'b0;
      if (resp) begin
        iter_done = 1'b1;
        syn_wt = v.w[idx][7:0];
        if (idx < 7) idx++;
        resp = 1'b0;
      end
      if (iter_start) begin
        nl++;
        resp = 1'b1;
      end
      if (capture_best) nc++;
      if (done) fin = 1'b1;
    end
    start = 1'b0;
    iter_done = 1'b0;
    chk({tag, " done seen"}, int'(fin), 1);
    chk({tag, " reason"}, int'(reason), v.rsn);
    chk({tag, " pass"}, int'(pass), v.ps);
    chk({tag, " iter_cnt"}, int'(iter_cnt), v.it);
    chk({tag, " best_wt"}, int'(best_wt), v.bw);
    chk({tag, " best_iter"}, int'(best_iter), v.bi);
    chk({tag, " busy at done"}, int'(busy), 0);
    chk({tag, " launches"}, nl, v.nl);
    chk({tag, " captures"}, nc, v.nc);
  endtask
  initial begin
    int n;
    clr = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    iter_done = 1'b0;
    syn_wt = 8'd0;
    cfg_max_iter = 8'd0;
    cfg_wt_thresh = 8'd0;
    cfg_stall_lim = 4'd0;
    cfg_stall_en = 1'b0;
    vt[0] = '{mx:10, th:0, lim:0, sen:0, poke:0, w:'{7,3,0,0,0,0,0,0}, rsn:0, ps:1, it:3, bw:0, bi:3, nl:3, nc:3};
    vt[1] = '{mx:4, th:0, lim:0, sen:0, poke:0, w:'{5,5,5,5,5,5,5,5}, rsn:1, ps:0, it:4, bw:5, bi:1, nl:4, nc:1};
    vt[2] = '{mx:0, th:0, lim:0, sen:0, poke:0, w:'{5,5,5,5,5,5,5,5}, rsn:1, ps:0, it:1, bw:5, bi:1, nl:1, nc:1};
    vt[3] = '{mx:20, th:0, lim:2, sen:1, poke:0, w:'{9,6,6,7,7,7,7,7}, rsn:2, ps:0, it:4, bw:6, bi:2, nl:4, nc:2};
    vt[4] = '{mx:6, th:0, lim:2, sen:0, poke:0, w:'{9,6,6,7,7,7,7,7}, rsn:1, ps:0, it:6, bw:6, bi:2, nl:6, nc:2};
    vt[5] = '{mx:10, th:4, lim:0, sen:0, poke:0, w:'{10,4,0,0,0,0,0,0}, rsn:0, ps:1, it:2, bw:4, bi:2, nl:2, nc:2};
    vt[6] = '{mx:3, th:0, lim:0, sen:1, poke:0, w:'{5,5,5,5,5,5,5,5}, rsn:1, ps:0, it:3, bw:5, bi:1, nl:3, nc:1};
    vt[7] = '{mx:3, th:0, lim:0, sen:0, poke:1, w:'{5,5,5,5,5,5,5,5}, rsn:1, ps:0, it:3, bw:5, bi:1, nl:3, nc:1};
    repeat (3) @(negedge clk);
    chk_reset("reset");
    clr = 1'b0;
    @(negedge clk);
    iter_done = 1'b1;
    @(negedge clk);
    iter_done = 1'b0;
    chk("stray iter_done busy", int'(busy), 0);
    chk("stray iter_done launch", int'(iter_start), 0);
    @(negedge clk);
    chk("stray iter_done done", int'(done), 0);
    chk("stray iter_done best_wt", int'(best_wt), 255);
    for (int i = 0; i < 8; i++) run(vt[i], $sformatf("vec%0d", i));
    go(10, "abort wait");
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort wait done", int'(done), 1);
    chk("abort wait reason", int'(reason), 3);
    chk("abort wait pass", int'(pass), 0);
    chk("abort wait iter_cnt", int'(iter_cnt), 0);
    n = 0;
    repeat (4) begin
      @(negedge clk);
      n += int'(iter_start);
    end
    chk("abort wait no relaunch", n, 0);
    go(10, "abort conv");
    @(negedge clk);
    iter_done = 1'b1;
    syn_wt = 8'd0;
    abort = 1'b1;
    @(negedge clk);
    iter_done = 1'b0;
    abort = 1'b0;
    chk("abort conv capture", int'(capture_best), 1);
    @(negedge clk);
    chk("abort conv done", int'(done), 1);
    chk("abort conv reason", int'(reason), 0);
    chk("abort conv pass", int'(pass), 1);
    chk("abort conv iter_cnt", int'(iter_cnt), 1);
    go(10, "abort eval");
    @(negedge clk);
    iter_done = 1'b1;
    syn_wt = 8'd5;
    abort = 1'b1;
    @(negedge clk);
    iter_done = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("abort eval done", int'(done), 1);
    chk("abort eval reason", int'(reason), 3);
    chk("abort eval pass", int'(pass), 0);
    chk("abort eval best_wt", int'(best_wt), 5);
    go(10, "midrst");
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk_reset("midrst");
    iter_done = 1'b1;
    syn_wt = 8'd0;
    @(negedge clk);
    iter_done = 1'b0;
    n = 0;
    repeat (5) begin
      n += int'(done) + int'(busy) + int'(iter_start) + int'(capture_best);
      @(negedge clk);
    end
    chk("midrst quiet", n, 0);
    chk("midrst best_wt", int'(best_wt), 255);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
